ezusb_lsi2: RTL and testbench



---
 rtl/ezusb_lsi2_pkg.sv | 18 +
 rtl/ezusb_lsi2_sync.sv | 50 +++++
 rtl/ezusb_lsi2.sv | 174 +++++++++++++++++
 tb/tb_ezusb_lsi2.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ezusb_lsi2_pkg.sv
// Shared types for the second-generation EZ-USB low-speed link.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package ezusb_lsi2_pkg;

   typedef enum logic [1:0] {
      SHIFT_IN  = 2'd0,
      WAIT_DATA = 2'd1,
      SHIFT_OUT = 2'd2
   } state_e;

   // Bit counter width. Two values of headroom above the frame length make
   // sure a saturated (overlong) count can never equal the legal length.
   function automatic int cnt_width(input int frame_bits);
      return $clog2(frame_bits + 2);
   endfunction

endpackage

// File: rtl/ezusb_lsi2_sync.sv
// Synchroniser and edge detector for data_clk, plus synchronised mosi and stop.
// Latency: edge_o rises SYNC_STAGES+1 clk cycles after a data_clk level change.
// Backpressure: none; one edge_o pulse per data_clk level change.
//
// Ports: clk_i, rst_ni (async active-low), data_clk_i/mosi_i/stop_i raw pins,
//        edge_o one-cycle edge pulse, mosi_o/stop_o synchronised levels.
module ezusb_lsi2_sync #(
   parameter int SYNC_STAGES = 3
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic data_clk_i,
   input  logic mosi_i,
   input  logic stop_i,
   output logic edge_o,
   output logic mosi_o,
   output logic stop_o
);

   logic [SYNC_STAGES-1:0] dclk_q;
   logic [SYNC_STAGES-1:0] mosi_q;
   logic [SYNC_STAGES-1:0] stop_q;
   logic                   dclk_prev_q;
   logic                   level_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         dclk_q      <= '0;
         mosi_q      <= '0;
         stop_q      <= '0;
         dclk_prev_q <= 1'b0;
         level_q     <= 1'b0;
      end else begin
         dclk_q      <= {dclk_q[SYNC_STAGES-2:0], data_clk_i};
         mosi_q      <= {mosi_q[SYNC_STAGES-2:0], mosi_i};
         stop_q      <= {stop_q[SYNC_STAGES-2:0], stop_i};
         dclk_prev_q <= dclk_q[SYNC_STAGES-1];
         if (edge_o) begin
            level_q <= dclk_prev_q;
         end
      end
   end

   // Two agreeing newest samples that differ from the stored level; the
   // level update on the same cycle makes this a single-cycle pulse.
   assign edge_o = (dclk_q[SYNC_STAGES-1] == dclk_prev_q) && (dclk_prev_q != level_q);
   assign mosi_o = mosi_q[SYNC_STAGES-1];
   assign stop_o = stop_q[SYNC_STAGES-1];

endmodule

// File: rtl/ezusb_lsi2.sv
// SRAM-like register port over the three-wire EZ-USB link (data_clk/mosi/stop, LSB first).
// Latency: edge seen SYNC_STAGES+1 cycles after a pin toggle; strobes/out_req one cycle later.
// Backpressure: out_req held until out_ready; host may abort by dropping stop.
//
// Ports: clk, reset_n (async active-low), reset (sync reset for user logic),
//        data_clk/mosi/stop/miso link pins, in_addr/in_data/in_strobe/in_valid/frame_err
//        write side, out_addr/out_req/out_data/out_ready read-back side.
// Optional: define EZUSB_LSI2_PARITY_EN to add an even-parity bit to both directions.
module ezusb_lsi2
   import ezusb_lsi2_pkg::*;
#(
   parameter int ADDR_WIDTH  = 8,
   parameter int DATA_WIDTH  = 32,
   parameter int SYNC_STAGES = 3
) (
   input  logic                  clk,
   input  logic                  reset_n,
   output logic                  reset,
   input  logic                  data_clk,
   input  logic                  mosi,
   output logic                  miso,
   input  logic                  stop,
   output logic [ADDR_WIDTH-1:0] in_addr,
   output logic [DATA_WIDTH-1:0] in_data,
   output logic                  in_strobe,
   output logic                  in_valid,
   output logic                  frame_err,
   output logic [ADDR_WIDTH-1:0] out_addr,
   output logic                  out_req,
   input  logic [DATA_WIDTH-1:0] out_data,
   input  logic                  out_ready
);

`ifdef EZUSB_LSI2_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int FRAME = ADDR_WIDTH + DATA_WIDTH + PAR;
   localparam int WR_W  = DATA_WIDTH + PAR;
   localparam int CNT_W = cnt_width(FRAME);

   // Reset for user logic: asserted with reset_n, released on the second edge.
   logic [1:0] rst_sync_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rst_sync_q <= 2'b11;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b0};
      end
   end

   assign reset = rst_sync_q[1];

   logic edge_s, mosi_s, stop_s;

   ezusb_lsi2_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk_i      (clk),
      .rst_ni     (reset_n),
      .data_clk_i (data_clk),
      .mosi_i     (mosi),
      .stop_i     (stop),
      .edge_o     (edge_s),
      .mosi_o     (mosi_s),
      .stop_o     (stop_s)
   );

   state_e                  state_q;
   logic [FRAME-1:0]        read_reg_q;
   logic [WR_W-1:0]         write_reg_q;
   logic [CNT_W-1:0]        bit_cnt_q;
   logic [ADDR_WIDTH-1:0]   in_addr_q, out_addr_q;
   logic [DATA_WIDTH-1:0]   in_data_q;
   logic                    in_strobe_q, in_valid_q, frame_err_q, out_req_q;
   logic                    stop_prev_q;

   logic                    par_ok;
   logic [WR_W-1:0]         wr_load;
`ifdef EZUSB_LSI2_PARITY_EN
   assign par_ok  = ~(^read_reg_q);
   assign wr_load = {^out_data, out_data};
`else
   assign par_ok  = 1'b1;
   assign wr_load = out_data;
`endif

   // A stop fall coinciding with a data edge wins: that edge carries no bit.
   logic stop_fall, shift_edge, frame_ok;
   assign stop_fall  = stop_prev_q & ~stop_s;
   assign shift_edge = edge_s & ~stop_fall;
   assign frame_ok   = (bit_cnt_q == CNT_W'(FRAME)) && par_ok;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= SHIFT_IN;
         read_reg_q  <= '0;
         write_reg_q <= '0;
         bit_cnt_q   <= '0;
         in_addr_q   <= '0;
         in_data_q   <= '0;
         out_addr_q  <= '0;
         in_strobe_q <= 1'b0;
         in_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         out_req_q   <= 1'b0;
         stop_prev_q <= 1'b0;
      end else begin
         in_strobe_q <= 1'b0;
         frame_err_q <= 1'b0;
         stop_prev_q <= stop_s;
         case (state_q)
            SHIFT_IN: begin
               if (shift_edge) begin
                  if (!stop_s) begin
                     read_reg_q <= {mosi_s, read_reg_q[FRAME-1:1]};
                     if (bit_cnt_q != '1) begin
                        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                     end
                  end else if (!mosi_s) begin
                     bit_cnt_q <= '0;
                     if (frame_ok) begin
                        // The parity bit, when present, sits above the address.
                        in_addr_q   <= read_reg_q[ADDR_WIDTH+DATA_WIDTH-1 -: ADDR_WIDTH];
                        in_data_q   <= read_reg_q[DATA_WIDTH-1:0];
                        in_strobe_q <= 1'b1;
                        in_valid_q  <= 1'b1;
                     end else begin
                        frame_err_q <= 1'b1;
                     end
                  end else begin
                     // Read request: only the address bits were shifted in,
                     // so they occupy the top of the register.
                     bit_cnt_q  <= '0;
                     out_addr_q <= read_reg_q[FRAME-1 -: ADDR_WIDTH];
                     out_req_q  <= 1'b1;
                     state_q    <= WAIT_DATA;
                  end
               end
            end
            WAIT_DATA: begin
               if (!stop_s) begin
                  out_req_q <= 1'b0;
                  state_q   <= SHIFT_IN;
               end else if (out_ready) begin
                  write_reg_q <= wr_load;
                  out_req_q   <= 1'b0;
                  state_q     <= SHIFT_OUT;
               end
            end
            SHIFT_OUT: begin
               if (!stop_s) begin
                  state_q <= SHIFT_IN;
               end else if (edge_s) begin
                  write_reg_q <= {1'b0, write_reg_q[WR_W-1:1]};
               end
            end
            default: state_q <= SHIFT_IN;
         endcase
      end
   end

   assign miso      = write_reg_q[0];
   assign in_addr   = in_addr_q;
   assign in_data   = in_data_q;
   assign in_strobe = in_strobe_q;
   assign in_valid  = in_valid_q;
   assign frame_err = frame_err_q;
   assign out_addr  = out_addr_q;
   assign out_req   = out_req_q;

endmodule

// File: tb/tb_ezusb_lsi2.sv
// Self-checking bench for ezusb_lsi2: directed table, hand sequences, random ops vs model.
module tb_ezusb_lsi2;

   localparam int AW = 8;
   localparam int DW = 32;
   localparam int SS = 3;
`ifdef EZUSB_LSI2_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int FW   = AW + DW + PAR;
   localparam int HOLD = SS + 4;
   localparam int NRD  = DW + PAR + 2;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          reset;
   logic          data_clk = 1'b0;
   logic          mosi = 1'b0;
   logic          miso;
   logic          stop = 1'b0;
   logic [AW-1:0] in_addr;
   logic [DW-1:0] in_data;
   logic          in_strobe;
   logic          in_valid;
   logic          frame_err;
   logic [AW-1:0] out_addr;
   logic          out_req;
   logic [DW-1:0] out_data = '0;
   logic          out_ready = 1'b0;

   ezusb_lsi2 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SYNC_STAGES(SS)) dut (
      .clk(clk), .reset_n(reset_n), .reset(reset), .data_clk(data_clk),
      .mosi(mosi), .miso(miso), .stop(stop), .in_addr(in_addr), .in_data(in_data),
      .in_strobe(in_strobe), .in_valid(in_valid), .frame_err(frame_err),
      .out_addr(out_addr), .out_req(out_req), .out_data(out_data), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int strobe_cnt = 0;
   int err_cnt = 0;

   always @(posedge clk) begin
      #1;
      if (in_strobe) strobe_cnt++;
      if (frame_err) err_cnt++;
   end

   // Reference model of the user-visible write-side state.
   logic [AW-1:0] m_addr = '0;
   logic [DW-1:0] m_data = '0;
   logic          m_valid = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [FW-1:0] mk_frame(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                              input bit badp);
      logic [FW-1:0] f;
      f = '0;
      f[AW+DW-1:0] = {a, d};
      if (PAR == 1) f[FW-1] = (^{a, d}) ^ badp;
      return f;
   endfunction

   task automatic send_bit(input logic b, input logic s);
      mosi = b;
      stop = s;
      data_clk = ~data_clk;
      repeat (HOLD) @(negedge clk);
   endtask

   task automatic write_frame(input logic [FW-1:0] f, input int nbits, output int ds, output int de);
      int s0, e0;
      logic bv;
      s0 = strobe_cnt;
      e0 = err_cnt;
      for (int i = 0; i < nbits; i++) begin
         bv = (i < FW) ? f[i] : 1'b0;
         send_bit(bv, 1'b0);
      end
      send_bit(1'b0, 1'b1);
      stop = 1'b0;
      repeat (HOLD) @(negedge clk);
      ds = strobe_cnt - s0;
      de = err_cnt - e0;
   endtask

   task automatic apply_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input int nbits,
                              input bit badp);
      int ds, de;
      bit ok;
      write_frame(mk_frame(a, d, badp), nbits, ds, de);
      ok = (nbits == FW) && !(PAR == 1 && badp);
      if (ok) begin
         m_addr = a;
         m_data = d;
         m_valid = 1'b1;
      end
      chk("wr_strobe_cnt", 64'(ds), 64'(ok));
      chk("wr_ferr_cnt", 64'(de), 64'(!ok));
      chk("wr_in_addr", 64'(in_addr), 64'(m_addr));
      chk("wr_in_data", 64'(in_data), 64'(m_data));
      chk("wr_in_valid", 64'(in_valid), 64'(m_valid));
   endtask

   task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] d, input int delay,
                          input bit abort);
      logic [NRD-1:0] es;
      int n;
      for (int i = 0; i < AW; i++) send_bit(a[i], 1'b0);
      if (delay == 0) begin
         out_data = d;
         out_ready = 1'b1;
      end
      mosi = 1'b1;
      stop = 1'b1;
      data_clk = ~data_clk;
      if (delay == 0) begin
         repeat (HOLD) @(negedge clk);
         out_ready = 1'b0;
         chk("rd_req_done", 64'(out_req), 64'd0);
      end else begin
         n = 0;
         while (!out_req && n < 40) begin
            @(negedge clk);
            n++;
         end
         chk("rd_req_rise", 64'(out_req), 64'd1);
         if (abort) begin
            stop = 1'b0;
            repeat (HOLD) @(negedge clk);
            chk("rd_abort_req", 64'(out_req), 64'd0);
            chk("rd_abort_addr", 64'(out_addr), 64'(a));
            return;
         end
         repeat (delay - 1) @(negedge clk);
         chk("rd_req_held", 64'(out_req), 64'd1);
         out_data = d;
         out_ready = 1'b1;
         @(negedge clk);
         out_ready = 1'b0;
         chk("rd_req_fall", 64'(out_req), 64'd0);
         chk("rd_miso_first", 64'(miso), 64'(d[0]));
         repeat (HOLD) @(negedge clk);
      end
      chk("rd_out_addr", 64'(out_addr), 64'(a));
      es = '0;
      es[DW-1:0] = d;
      if (PAR == 1) es[DW] = ^d;
      for (int j = 0; j < NRD; j++) begin
         chk("rd_miso_bit", 64'(miso), 64'(es[j]));
         send_bit(1'b0, 1'b1);
      end
      stop = 1'b0;
      repeat (HOLD) @(negedge clk);
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_in_valid"}, 64'(in_valid), 64'd0);
      chk({tag, "_in_addr"}, 64'(in_addr), 64'd0);
      chk({tag, "_in_data"}, 64'(in_data), 64'd0);
      chk({tag, "_out_addr"}, 64'(out_addr), 64'd0);
      chk({tag, "_out_req"}, 64'(out_req), 64'd0);
      chk({tag, "_strobes"}, 64'({in_strobe, frame_err}), 64'd0);
      chk({tag, "_miso"}, 64'(miso), 64'd0);
      chk({tag, "_reset"}, 64'(reset), 64'd1);
   endtask

   task automatic release_reset();
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      chk("reset_after_1_edge", 64'(reset), 64'd1);
      @(negedge clk);
      chk("reset_after_2_edges", 64'(reset), 64'd0);
      repeat (HOLD) @(negedge clk);
   endtask

   typedef struct {
      int            nbits;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      bit            exp_ok;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
   } vec_t;

   vec_t tbl[7];

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int ds, de;
      tbl[0] = '{FW,     8'h12, 32'hDEADBEEF, 1'b1, 8'h12, 32'hDEADBEEF};
      tbl[1] = '{FW - 1, 8'h34, 32'h11223344, 1'b0, 8'h12, 32'hDEADBEEF};
      tbl[2] = '{FW,     8'hA5, 32'h00000001, 1'b1, 8'hA5, 32'h00000001};
      tbl[3] = '{FW + 1, 8'h77, 32'hFFFFFFFF, 1'b0, 8'hA5, 32'h00000001};
      tbl[4] = '{0,      8'h00, 32'h00000000, 1'b0, 8'hA5, 32'h00000001};
      tbl[5] = '{FW,     8'hFF, 32'hFFFFFFFF, 1'b1, 8'hFF, 32'hFFFFFFFF};
      tbl[6] = '{FW,     8'h00, 32'h00000000, 1'b1, 8'h00, 32'h00000000};

      repeat (3) @(negedge clk);
      check_reset_state("por");
      release_reset();

      for (int k = 0; k < 7; k++) begin
         write_frame(mk_frame(tbl[k].a, tbl[k].d, 1'b0), tbl[k].nbits, ds, de);
         chk("tbl_strobe", 64'(ds), 64'(tbl[k].exp_ok));
         chk("tbl_ferr", 64'(de), 64'(!tbl[k].exp_ok));
         chk("tbl_in_addr", 64'(in_addr), 64'(tbl[k].ea));
         chk("tbl_in_data", 64'(in_data), 64'(tbl[k].ed));
         chk("tbl_in_valid", 64'(in_valid), 64'd1);
         m_valid = 1'b1;
         m_addr = tbl[k].ea;
         m_data = tbl[k].ed;
      end

      // Read with a 7-cycle user delay, then host abort, then a write.
      do_read(8'h05, 32'h0000A5A5, 7, 1'b0);
      do_read(8'h3C, 32'h12345678, 3, 1'b1);
      apply_write(8'h5A, 32'hCAFEF00D, FW, 1'b0);
      // out_ready held high throughout.
      do_read(8'h81, 32'h80000001, 0, 1'b0);
      apply_write(8'h11, 32'h0BADF00D, FW, 1'b0);

      // Reset in the middle of a write frame.
      for (int i = 0; i < 20; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
      reset_n = 1'b0;
      data_clk = 1'b0;
      mosi = 1'b0;
      stop = 1'b0;
      @(negedge clk);
      check_reset_state("mid");
      m_addr = '0;
      m_data = '0;
      m_valid = 1'b0;
      release_reset();
      apply_write(8'h12, 32'hDEADBEEF, FW, 1'b0);

      // Random mix of writes (good, wrong length, bad parity) and reads.
      repeat (30) begin
         int op, nb, dly;
         logic [AW-1:0] ra;
         logic [DW-1:0] rd;
         op = $urandom_range(0, 9);
         ra = AW'($urandom);
         rd = DW'($urandom);
         if (op < 5) begin
            apply_write(ra, rd, FW, bit'($urandom_range(0, 3) == 0));
         end else if (op == 5) begin
            nb = ($urandom_range(0, 1) == 1) ? FW + 1 : FW - 1 - $urandom_range(0, 5);
            apply_write(ra, rd, nb, 1'b0);
         end else begin
            dly = $urandom_range(0, 5);
            if (op == 9 && dly == 0) dly = 2;
            do_read(ra, rd, dly, op == 9);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
